// File: rtl/shower_win.sv
// shower_win -- parametrised anode shower detector.
//
// Counts hit wires per layer, delays {layer mask, hit count} by a programmable
// drift time, sums the counts over a sliding window of WIN bx and grades the
// sum against loose/nominal/tight thresholds. It also gates the result on a
// minimum number of hit layers, applies a post-trigger holdoff and honours
// trig_stop.
//
// Optional feature: define SHOWER_CNT_EN to add saturating per-level event
// counters (cnt_clr / cnt_loose / cnt_nominal / cnt_tight).
//
// Ports
//   clk, rst_n   40 MHz bx clock, asynchronous active-low reset
//   ly           layer-major hit bits, layer k = ly[k*NWIRES +: NWIRES]
//   th_loose/th_nominal/th_tight   window hit-count thresholds (0 = always pass)
//   ly_thr       minimum number of layers with hits inside the window
//   drifttime    delay tap in bx (values >= MAXDLY clamp to MAXDLY-1)
//   holdoff_bx   bx forced to 0 after a nonzero output (0 = no holdoff)
//   trig_stop    suppress output; the pipeline keeps running
//   shower_int   0 none, 1 loose, 2 nominal, 3 tight
//   cnt_*        (SHOWER_CNT_EN only) clear input and 16-bit event counters
//
// Latency: hits in bx t appear on shower_int at t+3+drifttime for WIN bx.

// Per-layer hit count and layer-hit flag.
module shower_win_layer #(
  parameter int NWIRES = 48,
  parameter int CLW    = $clog2(NWIRES+1)
) (
  input  logic [NWIRES-1:0] w,
  output logic [CLW-1:0]    cnt,
  output logic              hit
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NWIRES; i++) cnt = cnt + CLW'(w[i]);
  end
  assign hit = |w;
endmodule

module shower_win #(
  parameter int NLAYERS = 6,
  parameter int NWIRES  = 48,
  parameter int MAXDLY  = 8,
  parameter int WIN     = 2,
  localparam int CW  = $clog2(NLAYERS*NWIRES*WIN+1),
  localparam int LW  = $clog2(NLAYERS+1),
  localparam int DW  = (MAXDLY > 1) ? $clog2(MAXDLY) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NLAYERS*NWIRES-1:0] ly,
  input  logic [CW-1:0]             th_loose,
  input  logic [CW-1:0]             th_nominal,
  input  logic [CW-1:0]             th_tight,
  input  logic [LW-1:0]             ly_thr,
  input  logic [DW-1:0]             drifttime,
  input  logic [3:0]                holdoff_bx,
  input  logic                      trig_stop,
`ifdef SHOWER_CNT_EN
  input  logic                      cnt_clr,
  output logic [15:0]               cnt_loose,
  output logic [15:0]               cnt_nominal,
  output logic [15:0]               cnt_tight,
`endif
  output logic [1:0]                shower_int
);
  localparam int CC  = $clog2(NLAYERS*NWIRES+1);  // one-bx hit count width
  localparam int CLW = $clog2(NWIRES+1);
  localparam logic [DW:0]   DLIM = MAXDLY[DW:0];
  localparam logic [DW-1:0] DTOP = DW'(MAXDLY-1);

  typedef struct packed {
    logic [NLAYERS-1:0] m;
    logic [CC-1:0]      c;
  } ent_t;

  // ---- S1: per-layer counts, combined into one entry --------------------
  logic [NLAYERS-1:0][CLW-1:0] lcnt;
  logic [NLAYERS-1:0]          lhit;
  logic [CC-1:0]               c_nxt;

  for (genvar k = 0; k < NLAYERS; k++) begin : g_layer
    shower_win_layer #(.NWIRES(NWIRES), .CLW(CLW)) u_layer (
      .w   (ly[k*NWIRES +: NWIRES]),
      .cnt (lcnt[k]),
      .hit (lhit[k])
    );
  end

  always_comb begin
    c_nxt = '0;
    for (int k = 0; k < NLAYERS; k++) c_nxt = c_nxt + CC'(lcnt[k]);
  end

  // dl[0] is the S1 register itself; dl[i] is S1 delayed by i bx.
  ent_t dl [MAXDLY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAXDLY; i++) dl[i] <= '0;
    end else begin
      dl[0] <= '{m: lhit, c: c_nxt};
      for (int i = 1; i < MAXDLY; i++) dl[i] <= dl[i-1];
    end
  end

  // ---- tap select; out-of-range drift times clamp to the deepest tap ----
  logic [DW-1:0] tsel;
  ent_t          tap;

  always_comb begin
    tsel = ({1'b0, drifttime} >= DLIM) ? DTOP : drifttime;
    tap  = dl[tsel];
  end

  // ---- sliding window of the last WIN tapped entries --------------------
  ent_t win [WIN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < WIN; j++) win[j] <= '0;
    end else begin
      win[0] <= tap;
      for (int j = 1; j < WIN; j++) win[j] <= win[j-1];
    end
  end

  logic [CW-1:0]      wsum;
  logic [NLAYERS-1:0] wmask;
  logic [LW-1:0]      nly;

  always_comb begin
    wsum  = '0;
    wmask = '0;
    for (int j = 0; j < WIN; j++) begin
      wsum  = wsum + CW'(win[j].c);
      wmask = wmask | win[j].m;
    end
    nly = '0;
    for (int k = 0; k < NLAYERS; k++) nly = nly + LW'(wmask[k]);
  end

  // ---- classification, holdoff and output register ----------------------
  logic [1:0] lvl, out_nxt;
  logic [3:0] hcnt, hcnt_nxt;

  always_comb begin
    lvl = 2'd0;
    if      (wsum >= th_tight)   lvl = 2'd3;
    else if (wsum >= th_nominal) lvl = 2'd2;
    else if (wsum >= th_loose)   lvl = 2'd1;
    if (nly < ly_thr) lvl = 2'd0;

    out_nxt = (hcnt != 4'd0 || trig_stop) ? 2'd0 : lvl;

    // A running holdoff always counts down (also under trig_stop); a new
    // one only starts from an output that is actually emitted.
    if (hcnt != 4'd0)         hcnt_nxt = hcnt - 4'd1;
    else if (out_nxt != 2'd0) hcnt_nxt = holdoff_bx;
    else                      hcnt_nxt = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shower_int <= 2'd0;
      hcnt       <= 4'd0;
    end else begin
      shower_int <= out_nxt;
      hcnt       <= hcnt_nxt;
    end
  end

`ifdef SHOWER_CNT_EN
  // Saturating event counters; clear wins over a same-bx increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_loose   <= '0;
      cnt_nominal <= '0;
      cnt_tight   <= '0;
    end else if (cnt_clr) begin
      cnt_loose   <= '0;
      cnt_nominal <= '0;
      cnt_tight   <= '0;
    end else begin
      if (out_nxt == 2'd1 && cnt_loose   != 16'hFFFF) cnt_loose   <= cnt_loose   + 16'd1;
      if (out_nxt == 2'd2 && cnt_nominal != 16'hFFFF) cnt_nominal <= cnt_nominal + 16'd1;
      if (out_nxt == 2'd3 && cnt_tight   != 16'hFFFF) cnt_tight   <= cnt_tight   + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shower_win.sv
// Testbench for shower_win: directed scenarios plus randomized traffic, every
// bx checked against a bx-indexed reference model of the detector's rules.
module tb_shower_win;
  localparam int NL = 6;
  localparam int NW = 48;
  localparam int MD = 6;   // not a power of two, so out-of-range drift times exist
  localparam int WN = 2;
  localparam int CW = $clog2(NL*NW*WN+1);
  localparam int LW = $clog2(NL+1);
  localparam int DW = $clog2(MD);
  localparam int HN = 4096;  // history ring depth (bx)

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NL*NW-1:0] ly = '0;
  logic [CW-1:0]    th_loose, th_nominal, th_tight;
  logic [LW-1:0]    ly_thr;
  logic [DW-1:0]    drifttime;
  logic [3:0]       holdoff_bx;
  logic             trig_stop;
  logic [1:0]       shower_int;
`ifdef SHOWER_CNT_EN
  logic             cnt_clr = 1'b0;
  logic [15:0]      cnt_loose, cnt_nominal, cnt_tight;
`endif

  shower_win #(.NLAYERS(NL), .NWIRES(NW), .MAXDLY(MD), .WIN(WN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ly         (ly),
    .th_loose   (th_loose),
    .th_nominal (th_nominal),
    .th_tight   (th_tight),
    .ly_thr     (ly_thr),
    .drifttime  (drifttime),
    .holdoff_bx (holdoff_bx),
    .trig_stop  (trig_stop),
`ifdef SHOWER_CNT_EN
    .cnt_clr    (cnt_clr),
    .cnt_loose  (cnt_loose),
    .cnt_nominal(cnt_nominal),
    .cnt_tight  (cnt_tight),
`endif
    .shower_int (shower_int)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Per-bx record of what was applied during that bx.
  int rc [HN], rm [HN], rd [HN], rl [HN], rts [HN], rhob [HN];
  int rthl [HN], rthn [HN], rtht [HN], rlthr [HN], rclr [HN];
  int n = 0;          // current bx index
  int last_rst = 0;   // latest bx with reset asserted
  int blocked = -1;   // outputs up to this bx are held off
  int exp_out = 0;
  int e_lo = 0, e_no = 0, e_ti = 0;
  int lc [NL];
  int cur_sum = 0, cur_mask = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Place lc[k] hits in layer k as a run starting at a random wire.
  task automatic drive_ly();
    int off;
    ly = '0;
    cur_sum = 0;
    cur_mask = 0;
    for (int k = 0; k < NL; k++) begin
      if (lc[k] > 0) begin
        off = $urandom_range(0, NW-1);
        for (int i = 0; i < lc[k]; i++) ly[k*NW + (off+i)%NW] = 1'b1;
        cur_sum += lc[k];
        cur_mask |= (1 << k);
      end
    end
  endtask

  task automatic set_layers(input int nlay, input int per);
    for (int k = 0; k < NL; k++) lc[k] = (k < nlay) ? per : 0;
    drive_ly();
  endtask

  // Close the current bx, advance one clock and check the new output.
  // Output in bx T uses window entries captured at edges T-1..T-WN; the
  // entry captured at edge E comes from hits of bx E-2-drift(E-1).
  task automatic step();
    int i, s, msk, src, e, lv;
    i = n % HN;
    rc[i] = cur_sum;  rm[i] = cur_mask;
    rd[i] = (int'(drifttime) >= MD) ? MD-1 : int'(drifttime);
    rl[i] = (rst_n == 1'b0) ? 1 : 0;
    rts[i] = int'(trig_stop);  rhob[i] = int'(holdoff_bx);
    rthl[i] = int'(th_loose);  rthn[i] = int'(th_nominal);  rtht[i] = int'(th_tight);
    rlthr[i] = int'(ly_thr);
`ifdef SHOWER_CNT_EN
    rclr[i] = int'(cnt_clr);
`else
    rclr[i] = 0;
`endif
    if (!rst_n) last_rst = n;
    @(posedge clk);
    n++;
    #1;
    i = (n-1) % HN;
    if (rl[i] != 0) begin
      exp_out = 0; blocked = -1; e_lo = 0; e_no = 0; e_ti = 0;
    end else begin
      s = 0; msk = 0;
      for (int j = 1; j <= WN; j++) begin
        e = n - j;
        if (e >= 1) begin
          src = e - 2 - rd[(e-1) % HN];
          if (src > last_rst) begin
            s += rc[src % HN];
            msk |= rm[src % HN];
          end
        end
      end
      lv = (s >= rtht[i]) ? 3 : (s >= rthn[i]) ? 2 : (s >= rthl[i]) ? 1 : 0;
      if ($countones(msk) < rlthr[i]) lv = 0;
      if (rts[i] != 0 || n <= blocked) exp_out = 0;
      else begin
        exp_out = lv;
        if (lv != 0) blocked = n + rhob[i];
      end
      if (rclr[i] != 0) begin
        e_lo = 0; e_no = 0; e_ti = 0;
      end else begin
        if (exp_out == 1 && e_lo < 65535) e_lo++;
        if (exp_out == 2 && e_no < 65535) e_no++;
        if (exp_out == 3 && e_ti < 65535) e_ti++;
      end
    end
    check("model_out", shower_int, exp_out);
`ifdef SHOWER_CNT_EN
    check("model_cnt_loose", cnt_loose, e_lo);
    check("model_cnt_nominal", cnt_nominal, e_no);
    check("model_cnt_tight", cnt_tight, e_ti);
`endif
  endtask

  task automatic idle(input int nb);
    set_layers(0, 0);
    for (int k = 0; k < nb; k++) step();
  endtask

  initial begin
    th_loose = CW'(50); th_nominal = CW'(100); th_tight = CW'(150);
    ly_thr = LW'(5); drifttime = DW'(2); holdoff_bx = 4'd0; trig_stop = 1'b0;
    set_layers(0, 0);
    for (int k = 0; k < 3; k++) step();
    check("reset_state", shower_int, 0);
    rst_n = 1'b1;
    idle(8);

    // single bx of 120 hits -> nominal for WIN bx
    set_layers(6, 20); step();
    set_layers(0, 0);
    for (int k = 0; k < 4; k++) step();
    check("lat_t5", shower_int, 2);
    step(); check("lat_t6", shower_int, 2);
    step(); check("lat_t7", shower_int, 0);
    idle(6);

    // async reset mid-burst, then restart latency from release
    set_layers(6, 20); step();
    set_layers(0, 0);
    for (int k = 0; k < 4; k++) step();
    check("rst_pre", shower_int, 2);
    #2 rst_n = 1'b0;
    #1 check("rst_async", shower_int, 0);
    step(); step();
    rst_n = 1'b1; drifttime = DW'(0);
    set_layers(6, 20); step();
    set_layers(0, 0);
    check("rel_1", shower_int, 0);
    step(); check("rel_2", shower_int, 0);
    step(); check("rel_3", shower_int, 2);
    drifttime = DW'(2);
    idle(10);

    // holdoff 3 with a 4-bx tight burst
    holdoff_bx = 4'd3;
    set_layers(6, 30);
    for (int k = 0; k < 4; k++) step();
    set_layers(0, 0);
    step(); check("hold_t5", shower_int, 3);
    step(); check("hold_t6", shower_int, 0);
    step(); check("hold_t7", shower_int, 0);
    step(); check("hold_t8", shower_int, 0);
    step(); check("hold_t9", shower_int, 3);
    holdoff_bx = 4'd0;
    idle(10);

    // layer gate: 4 full layers = 192 hits
    set_layers(4, 48); step();
    set_layers(0, 0);
    for (int k = 0; k < 4; k++) step();
    check("gate5_t5", shower_int, 0);
    step(); check("gate5_t6", shower_int, 0);
    idle(6);
    ly_thr = LW'(4);
    set_layers(4, 48); step();
    set_layers(0, 0);
    for (int k = 0; k < 4; k++) step();
    check("gate4_t5", shower_int, 3);
    step(); check("gate4_t6", shower_int, 3);
    ly_thr = LW'(5);
    idle(6);

    // trig_stop suppresses output and does not start a holdoff
    holdoff_bx = 4'd3;
    set_layers(6, 20);
    for (int k = 0; k < 4; k++) step();
    set_layers(0, 0);
    trig_stop = 1'b1;
    step(); check("stop_t5", shower_int, 0);
    trig_stop = 1'b0;
    step(); check("stop_t6", shower_int, 3);
    step(); check("stop_t7", shower_int, 0);
    holdoff_bx = 4'd0;
    idle(10);

    // drifttime beyond range clamps to MAXDLY-1
    drifttime = DW'(MD+1);
    idle(10);
    set_layers(6, 20); step();
    set_layers(0, 0);
    for (int k = 0; k < 6; k++) step();
    check("clamp_t7", shower_int, 0);
    step(); check("clamp_t8", shower_int, 2);
    step(); check("clamp_t9", shower_int, 2);
    step(); check("clamp_t10", shower_int, 0);
    drifttime = DW'(2);
    idle(10);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        th_loose   = CW'($urandom_range(0, 300));
        th_nominal = CW'($urandom_range(0, 400));
        th_tight   = CW'($urandom_range(0, 576));
        ly_thr     = LW'($urandom_range(0, 6));
        holdoff_bx = 4'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 29) == 0) drifttime = DW'($urandom_range(0, 7));
      trig_stop = ($urandom_range(0, 9) == 0);
`ifdef SHOWER_CNT_EN
      cnt_clr = ($urandom_range(0, 49) == 0);
`endif
      for (int k = 0; k < NL; k++) lc[k] = 0;
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < NL; k++)
          lc[k] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, NW));
      drive_ly();
      step();
    end
    trig_stop = 1'b0;

`ifdef SHOWER_CNT_EN
    // saturation: continuous loose events (60 hits per window)
    cnt_clr = 1'b0;
    th_loose = CW'(50); th_nominal = CW'(100); th_tight = CW'(150);
    ly_thr = LW'(5); holdoff_bx = 4'd0; drifttime = DW'(2);
    idle(10);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    set_layers(6, 5);
    for (int k = 0; k < 65545; k++) step();
    check("sat_loose", cnt_loose, 16'hFFFF);
    cnt_clr = 1'b1; step();
    check("clr_prio", cnt_loose, 0);
    cnt_clr = 1'b0; step();
    check("post_clr", cnt_loose, 1);
    idle(10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
